// File: rtl/gray_step_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_step_arbiter_pkg : shared state encoding and Gray constants     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gray_step_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter value whose next step rolls back to 000.
  localparam logic [2:0] GRAY_WRAP = 3'b100;

  // Step order of the external counter; element 0 is the cleared value.
  localparam logic [7:0][2:0] GRAY_SEQ = {
    3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000
  };

  function automatic logic [2:0] gray_next(input logic [2:0] v);
    logic [2:0] r;
    r = GRAY_SEQ[0];
    for (int i = 0; i < 8; i++) begin
      if (GRAY_SEQ[3'(i)] == v) r = GRAY_SEQ[3'(i + 1)];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_step_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_rr_pick : round-robin winner search starting at a pointer       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gray_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   winner_idx,
  output logic               valid
);

  localparam int SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] pos;

  // ptr < NUM_REQ and offset < NUM_REQ, so one subtraction wraps the sum.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    pos        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + SUM_W'(i);
      if (pos >= SUM_W'(NUM_REQ)) pos = pos - SUM_W'(NUM_REQ);
      if (!valid && req[pos[PTR_W-1:0]]) begin
        valid                   = 1'b1;
        winner_idx              = pos[PTR_W-1:0];
        winner[pos[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_step_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_step_arbiter : round-robin owner of a shared 3-bit Gray counter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gray_step_arbiter
  import gray_step_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ-1:0]       Clr,
  input  logic [NUM_REQ*LEN_W-1:0] Len,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Done,
  output logic [2:0]               Result,
  output logic                     Wrapped,
  output logic                     Busy,
  output logic                     Cnt_En,
  output logic                     Cnt_Reset,
  input  logic [2:0]               Cnt_Value
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               wrap_acc_q, wrap_acc_d;
  logic               wrapped_q, wrapped_d;
  logic [2:0]         result_q, result_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic [NUM_REQ-1:0] pick_winner;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [LEN_W-1:0]   len_sel;
  logic               clr_sel;

  gray_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req        (Req),
    .ptr        (ptr_q),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner[i]) len_sel = Len[i*LEN_W +: LEN_W];
    end
    clr_sel = |(Clr & pick_winner);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    remaining_d = remaining_q;
    wrap_acc_d  = wrap_acc_q;
    wrapped_d   = wrapped_q;
    result_d    = result_q;
    grant_d     = grant_q;
    done_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_idx;
          remaining_d = len_sel;
          wrap_acc_d  = 1'b0;
          grant_d     = pick_winner;
          state_d     = clr_sel ? ST_CLEAR : ST_RUN;
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (Cnt_Value == GRAY_WRAP) wrap_acc_d = 1'b1;
        if (remaining_q == '0) state_d = ST_DONE;
        else                   remaining_d = remaining_q - 1'b1;
      end
      ST_DONE: begin
        // Published flags stay stable until the next burst completes.
        result_d  = Cnt_Value;
        wrapped_d = wrap_acc_q;
        done_d    = grant_q;
        grant_d   = '0;
        ptr_d     = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      remaining_q <= '0;
      wrap_acc_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      result_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      remaining_q <= remaining_d;
      wrap_acc_q  <= wrap_acc_d;
      wrapped_q   <= wrapped_d;
      result_q    <= result_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
    end
  end

  assign Grant     = grant_q;
  assign Done      = done_q;
  assign Result    = result_q;
  assign Wrapped   = wrapped_q;
  assign Busy      = (state_q != ST_IDLE);
  assign Cnt_En    = (state_q == ST_RUN);
  // Combinational with Reset so the counter clears on every edge it is held.
  assign Cnt_Reset = Reset | (state_q == ST_CLEAR);

endmodule
`default_nettype wire
